// File: rtl/axi2mem_tcdm_wr_pipe.sv
// axi2mem_tcdm_wr_pipe: pairs command-queue beats with RX data beats, buffers the
// pairs in a 2-entry skid FIFO and issues TCDM write requests from the FIFO head.
// A one-cycle synch pulse reports the id of each completed burst.
// Optional macro AXI2MEM_WR_RESP_WAIT_EN: track outstanding granted writes and hold
// the burst-complete pulse (and the next burst) until every write response is back.
module axi2mem_tcdm_wr_pipe #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned ID_WIDTH        = 6,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [ID_WIDTH-1:0]       trans_id_i,
   input  logic [ADDR_WIDTH-1:0]     trans_add_i,
   input  logic                      trans_last_i,
   input  logic                      trans_req_i,
   output logic                      trans_gnt_o,
   input  logic [DATA_WIDTH-1:0]     data_dat_i,
   input  logic [DATA_WIDTH/8-1:0]   data_strb_i,
   input  logic                      data_gnt_i,
   output logic                      data_req_o,
   output logic                      synch_req_o,
   output logic [ID_WIDTH-1:0]       synch_id_o,
   output logic                      tcdm_req_o,
   output logic [ADDR_WIDTH-1:0]     tcdm_add_o,
   output logic                      tcdm_we_o,
   output logic [DATA_WIDTH-1:0]     tcdm_wdata_o,
   output logic [DATA_WIDTH/8-1:0]   tcdm_be_o,
   input  logic                      tcdm_gnt_i,
   input  logic [DATA_WIDTH-1:0]     tcdm_r_rdata_i,
   input  logic                      tcdm_r_valid_i
);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]   add;
      logic [DATA_WIDTH-1:0]   dat;
      logic [DATA_WIDTH/8-1:0] strb;
      logic [ID_WIDTH-1:0]     id;
      logic                    last;
   } entry_t;

   entry_t              mem_q [2];
   entry_t              mem_d [2];
   logic                wr_ptr_q, wr_ptr_d;
   logic                rd_ptr_q, rd_ptr_d;
   logic [1:0]          cnt_q, cnt_d;
   logic                synch_q, synch_d;
   logic [ID_WIDTH-1:0] synch_id_q, synch_id_d;

   entry_t head;
   logic   head_vld;
   logic   head_wr;
   logic   issue_ok;
   logic   push;
   logic   pop;

   assign head     = mem_q[rd_ptr_q];
   assign head_vld = (cnt_q != 2'd0);
   assign head_wr  = |head.strb;

`ifdef AXI2MEM_WR_RESP_WAIT_EN
   localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

   logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
   logic                 pend_q, pend_d;
   logic [ID_WIDTH-1:0]  pend_id_q, pend_id_d;
   logic                 rsp;

   // Outstanding counter, pending-burst tracking and synch generation
   always_comb begin
      rsp        = tcdm_r_valid_i & (out_cnt_q != '0);
      issue_ok   = ~pend_q & ((out_cnt_q != CNT_WIDTH'(MAX_OUTSTANDING)) | rsp);
      out_cnt_d  = out_cnt_q + CNT_WIDTH'(tcdm_req_o & tcdm_gnt_i) - CNT_WIDTH'(rsp);
      pend_d     = pend_q;
      pend_id_d  = pend_id_q;
      synch_d    = 1'b0;
      synch_id_d = '0;
      if (pend_q && out_cnt_d == '0) begin
         synch_d    = 1'b1;
         synch_id_d = pend_id_q;
         pend_d     = 1'b0;
      end else if (pop && head.last) begin
         if (out_cnt_d == '0) begin
            synch_d    = 1'b1;
            synch_id_d = head.id;
         end else begin
            pend_d    = 1'b1;
            pend_id_d = head.id;
         end
      end
   end

   // Response-wait state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_cnt_q <= '0;
         pend_q    <= 1'b0;
         pend_id_q <= '0;
      end else begin
         out_cnt_q <= out_cnt_d;
         pend_q    <= pend_d;
         pend_id_q <= pend_id_d;
      end
   end

   logic unused_ok_c;
   assign unused_ok_c = ^tcdm_r_rdata_i;
`else
   // Synch follows the pop of a last beat directly; responses are not tracked
   always_comb begin
      issue_ok   = 1'b1;
      synch_d    = pop & head.last;
      synch_id_d = (pop & head.last) ? head.id : '0;
   end

   logic unused_ok_c;
   assign unused_ok_c = ^{tcdm_r_rdata_i, tcdm_r_valid_i, 1'(MAX_OUTSTANDING)};
`endif

   // Issue, pop and push handshakes; zero-strobe beats drain without a request
   always_comb begin
      tcdm_req_o  = head_vld & head_wr & issue_ok;
      pop         = head_vld & (head_wr ? (tcdm_req_o & tcdm_gnt_i) : issue_ok);
      push        = trans_req_i & data_gnt_i & ((cnt_q != 2'd2) | pop);
      trans_gnt_o = push;
      data_req_o  = push;
   end

   // TCDM payload from the head entry, zero when the FIFO is empty
   always_comb begin
      tcdm_we_o    = 1'b0;
      tcdm_add_o   = '0;
      tcdm_wdata_o = '0;
      tcdm_be_o    = '0;
      if (head_vld) begin
         tcdm_add_o   = head.add;
         tcdm_wdata_o = head.dat;
         tcdm_be_o    = head.strb;
      end
   end

   // FIFO next state
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{add: trans_add_i, dat: data_dat_i, strb: data_strb_i,
                             id: trans_id_i, last: trans_last_i};
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
   end

   // FIFO and synch registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= 2'd0;
         synch_q    <= 1'b0;
         synch_id_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         synch_q    <= synch_d;
         synch_id_q <= synch_id_d;
      end
   end

   assign synch_req_o = synch_q;
   assign synch_id_o  = synch_id_q;

endmodule
